room_draw_datapath: RTL



---
 rtl/room_draw_datapath.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/room_draw_datapath.sv
// Pixel generator for the room-status display: paints one 32x40 room tile,
// or clears the whole 160x120 screen, emitting one plotted pixel per clock.
module room_draw_datapath (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable0,
  input  logic       enable1,
  input  logic       enable2,
  input  logic       enable3,
  input  logic       enable4,
  input  logic       clearinitsignal,
  input  logic [4:0] light_state,
  input  logic [4:0] door_state,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       countDone
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE, HOLD} state_t;

  state_t     state;
  logic       job_clear;
  logic [2:0] room;
  logic       light_on;
  logic       door_open;
  logic [7:0] cx;
  logic [6:0] cy;

  logic [4:0] enables;
  logic [4:0] grant;
  logic [2:0] start_room;
  logic       any_request;
  logic       start_light;
  logic       start_door;
  logic       row_wrap;
  logic       last_pixel;
  logic [7:0] next_cx;
  logic [6:0] next_cy;

  function automatic logic [2:0] room_colour(input logic [7:0] px, input logic [6:0] py,
                                             input logic lit, input logic open);
    if (px >= 8'd12 && px <= 8'd19 && py >= 7'd32)
      return open ? 3'b010 : 3'b100;
    return lit ? 3'b110 : 3'b001;
  endfunction

  assign enables     = {enable4, enable3, enable2, enable1, enable0};
  assign any_request = clearinitsignal | (|enables);
  // Isolate the lowest set enable so the lowest room index wins.
  assign grant       = enables & (~enables + 5'd1);
  assign start_light = |(light_state & grant);
  assign start_door  = |(door_state & grant);

  always_comb begin
    start_room = 3'd0;
    if (enable0)      start_room = 3'd0;
    else if (enable1) start_room = 3'd1;
    else if (enable2) start_room = 3'd2;
    else if (enable3) start_room = 3'd3;
    else if (enable4) start_room = 3'd4;
  end

  assign row_wrap   = job_clear ? (cx == 8'd159) : (cx == 8'd31);
  assign last_pixel = row_wrap && (job_clear ? (cy == 7'd119) : (cy == 7'd39));
  assign next_cx    = row_wrap ? 8'd0 : cx + 8'd1;
  assign next_cy    = row_wrap ? cy + 7'd1 : cy;

  // cx/cy always name the pixel currently presented on x/y/colour.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      job_clear <= 1'b0;
      room      <= 3'd0;
      light_on  <= 1'b0;
      door_open <= 1'b0;
      cx        <= 8'd0;
      cy        <= 7'd0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'b000;
      plot      <= 1'b0;
      countDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot      <= 1'b0;
          countDone <= 1'b0;
          if (any_request) begin
            state <= DRAW;
            cx    <= 8'd0;
            cy    <= 7'd0;
            plot  <= 1'b1;
            if (clearinitsignal) begin
              job_clear <= 1'b1;
              room      <= 3'd0;
              light_on  <= 1'b0;
              door_open <= 1'b0;
              x         <= 8'd0;
              y         <= 7'd0;
              colour    <= 3'b000;
            end else begin
              job_clear <= 1'b0;
              room      <= start_room;
              light_on  <= start_light;
              door_open <= start_door;
              x         <= {start_room, 5'b00000};
              y         <= 7'd40;
              colour    <= start_light ? 3'b110 : 3'b001;
            end
          end
        end
        DRAW: begin
          if (!job_clear && clearinitsignal) begin
            // A clear request preempts a room in progress and restarts at the origin.
            job_clear <= 1'b1;
            cx        <= 8'd0;
            cy        <= 7'd0;
            x         <= 8'd0;
            y         <= 7'd0;
            colour    <= 3'b000;
            plot      <= 1'b1;
          end else if (last_pixel) begin
            state     <= DONE;
            plot      <= 1'b0;
            countDone <= 1'b1;
          end else begin
            cx   <= next_cx;
            cy   <= next_cy;
            plot <= 1'b1;
            if (job_clear) begin
              x      <= next_cx;
              y      <= next_cy;
              colour <= 3'b000;
            end else begin
              x      <= {room, 5'b00000} + next_cx;
              y      <= next_cy + 7'd40;
              colour <= room_colour(next_cx, next_cy, light_on, door_open);
            end
          end
        end
        DONE: begin
          state     <= HOLD;
          plot      <= 1'b0;
          countDone <= 1'b0;
        end
        HOLD: begin
          plot      <= 1'b0;
          countDone <= 1'b0;
          if (!any_request) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          plot      <= 1'b0;
          countDone <= 1'b0;
        end
      endcase
    end
  end

endmodule
